mem_port_arbiter: RTL and testbench

// Request-side controller in front of the 5-cycle slow word memory. Arbitrates an

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter in front of the slow word memory,
// one outstanding access, with misalignment and timeout error reporting.
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_valid,
  output logic                  if_err,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_valid,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_start,
  input  logic                  mem_rdy,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic                  gnt_d;
  logic                  last_d;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [TW-1:0]         tmo;
  logic                  pick_d;
  logic [31:0]           pick_addr;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    pick_d    = d_req & (~if_req | ~last_d);
    pick_addr = pick_d ? d_addr : if_addr;
  end

  // mem_we is only high in ISSUE/WAIT of a write, so it doubles as the bus drive enable.
  assign mem_data = mem_we ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt_d     <= 1'b0;
      last_d    <= 1'b1;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      tmo       <= '0;
      if_valid  <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_valid   <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      mem_start <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      if_valid  <= 1'b0;
      if_err    <= 1'b0;
      d_valid   <= 1'b0;
      d_err     <= 1'b0;
      mem_start <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_rdy && (if_req || d_req)) begin
            gnt_d   <= pick_d;
            last_d  <= pick_d;
            we_q    <= pick_d & d_we;
            wdata_q <= d_wdata;
            if (pick_addr[1:0] != 2'b00) begin
              if (pick_d) begin
                d_valid <= 1'b1;
                d_err   <= 1'b1;
              end else begin
                if_valid <= 1'b1;
                if_err   <= 1'b1;
              end
              state <= RESP;
            end else begin
              mem_start <= 1'b1;
              mem_addr  <= pick_addr;
              mem_we    <= pick_d & d_we;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          tmo   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mem_rdy) begin
            mem_we <= 1'b0;
            if (gnt_d) begin
              d_valid <= 1'b1;
              if (!we_q) d_rdata <= mem_data;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_data;
            end
            state <= RESP;
          end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the access; rdata keeps its previous value.
            mem_we <= 1'b0;
            if (gnt_d) begin
              d_valid <= 1'b1;
              d_err   <= 1'b1;
            end else begin
              if_valid <= 1'b1;
              if_err   <= 1'b1;
            end
            state <= RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter with a 5-cycle
// memory model that can be stalled to force timeouts.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic        if_err;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_start;
  logic        mem_rdy;
  logic        mem_we;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
    .mem_start(mem_start), .mem_rdy(mem_rdy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: busy for five cycles after start; read data driven in the rdy cycle.
  logic [31:0] mem_arr [16];
  logic [2:0]  busy;
  logic        we_l;
  logic [31:0] addr_l;
  logic        rd_out;
  logic        stall;

  assign mem_data = rd_out ? mem_arr[addr_l[5:2]] : 32'hzzzz_zzzz;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= 32'h0;
      mem_arr[2] <= 32'hDEAD_BEEF;
      busy    <= 3'd0;
      we_l    <= 1'b0;
      addr_l  <= 32'h0;
      rd_out  <= 1'b0;
      mem_rdy <= 1'b1;
    end else begin
      rd_out <= 1'b0;
      if (mem_start) begin
        busy    <= 3'd5;
        mem_rdy <= 1'b0;
        we_l    <= mem_we;
        addr_l  <= mem_addr;
        if (mem_we) mem_arr[mem_addr[5:2]] <= mem_data;
      end else if (busy != 3'd0 && !stall) begin
        busy <= busy - 3'd1;
        if (busy == 3'd1) begin
          mem_rdy <= 1'b1;
          rd_out  <= ~we_l;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output bit err,
                           output int starts, output int other, output bit drv_ok,
                           output bit rel_ok);
    lat = -1; err = 1'b0; starts = 0; other = 0; drv_ok = 1'b1; rel_ok = 1'b1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_start) starts++;
      if (is_d ? if_valid : d_valid) other++;
      if (is_d ? d_valid : if_valid) begin
        lat = n;
        err = is_d ? d_err : if_err;
        if (we && mem_data === wdata) rel_ok = 1'b0;
        break;
      end
      if (we && !(mem_we === 1'b1 && mem_data === wdata)) drv_ok = 1'b0;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, starts, other;
    bit err, drv_ok, rel_ok;
    int got[$];
    int at[$];
    int g, t;

    vecs[0] = '{1'b0, 1'b0, 32'h8,  32'h0,         8, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h10, 32'h1234_5678, 8, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h10, 32'h0,         8, 1'b0, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 32'h6,  32'h0,         1, 1'b1, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b0, 32'h3,  32'h0,         1, 1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b0, 32'h10, 32'h0,         8, 1'b0, 32'h1234_5678};
    vecs[6] = '{1'b1, 1'b1, 32'h4,  32'hA5A5_0F0F, 8, 1'b0, 32'h1234_5678};
    vecs[7] = '{1'b1, 1'b0, 32'h4,  32'h0,         8, 1'b0, 32'hA5A5_0F0F};

    reset = 1'b1; stall = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_d_valid", {31'b0, d_valid}, 32'h0);
    chk("rst_errs", {30'b0, if_err, d_err}, 32'h0);
    chk("rst_mem_start_we", {30'b0, mem_start, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Both ports requesting continuously: grants alternate starting with fetch.
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    for (int n = 1; n <= 60 && got.size() < 4; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (if_valid) begin got.push_back(0); at.push_back(n); end
      if (d_valid) begin got.push_back(1); at.push_back(n); end
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("arb_count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      g = (got.size() > i) ? got[i] : 9;
      t = (at.size() > i) ? at[i] : -1;
      chk($sformatf("arb_grant_%0d", i), g, i % 2);
      chk($sformatf("arb_time_%0d", i), t, 8 + 9 * i);
    end
    chk("arb_if_rdata", if_rdata, 32'hDEAD_BEEF);

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                lat, err, starts, other, drv_ok, rel_ok);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      chk($sformatf("v%0d_rdata", i), vecs[i].is_d ? d_rdata : if_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_mem_starts", i), starts, vecs[i].err ? 0 : 1);
      chk($sformatf("v%0d_other_valid", i), other, 32'd0);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_write_drive", i), {31'b0, drv_ok}, 32'h1);
        chk($sformatf("v%0d_bus_released", i), {31'b0, rel_ok}, 32'h1);
      end
    end

    // Memory never returns rdy: fetch times out after 16 WAIT cycles.
    stall = 1'b1;
    do_access(1'b0, 1'b0, 32'h0, 32'h0, lat, err, starts, other, drv_ok, rel_ok);
    chk("tmo_latency", lat, 32'd18);
    chk("tmo_err", {31'b0, err}, 32'h1);
    chk("tmo_rdata_kept", if_rdata, 32'h1234_5678);
    stall = 1'b0;
    for (int n = 0; n < 20 && !mem_rdy; n++) @(negedge clk);
    chk("tmo_mem_recover", {31'b0, mem_rdy}, 32'h1);
    do_access(1'b0, 1'b0, 32'h8, 32'h0, lat, err, starts, other, drv_ok, rel_ok);
    chk("post_tmo_latency", lat, 32'd8);
    chk("post_tmo_rdata", if_rdata, 32'hDEAD_BEEF);

    // Reset in the middle of WAIT aborts the access with no later response.
    if_req = 1'b1; if_addr = 32'h8;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("wait_mem_addr", mem_addr, 32'h8);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    chk("mid_rst_if_rdata", if_rdata, 32'h0);
    chk("mid_rst_d_rdata", d_rdata, 32'h0);
    chk("mid_rst_ctrl", {28'b0, mem_start, mem_we, if_valid, d_valid}, 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    other = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (if_valid || d_valid || mem_start) other++;
    end
    chk("post_rst_quiet", other, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
